// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Turns each single-cycle word load/store from the MEM stage into two
// half-word accesses on a 16-bit external SRAM: the low half first, then the
// high half. Each half is held on the bus for ACCESS_CYCLES cycles. While the
// access is in flight, ready is low, and the pipeline uses it as a freeze.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   mem_read     load request from the MEM stage
//   mem_write    store request from the MEM stage (wins over mem_read)
//   address      byte address from the ALU result
//   write_data   store data
//   read_data    loaded word, registered
//   ready        1 = idle or completing, 0 = freeze pipeline (combinational)
//   sram_addr    SRAM half-word address
//   sram_dq_out  data driven onto the SRAM bus on writes
//   sram_dq_oe   1 = controller drives the SRAM data bus
//   sram_dq_in   data returned by the SRAM
//   sram_we_n    SRAM write enable, active low
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] DATA_BASE     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int              CNT_W    = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_wr_q, is_wr_d;
    logic [16:0]      word_q, word_d;
    logic [15:0]      wdata_hi_q, wdata_hi_d;
    logic [31:0]      read_data_q, read_data_d;
    logic [17:0]      sram_addr_q, sram_addr_d;
    logic [15:0]      dq_out_q, dq_out_d;
    logic             dq_oe_q, dq_oe_d;
    logic             we_n_q, we_n_d;

    logic [31:0] off;
    logic        req;
    logic        unused_off_bits;

    // Offset wraps silently when the address is below DATA_BASE.
    assign off = address - DATA_BASE;
    assign req = mem_read | mem_write;
    // Only bits [18:2] select an SRAM word; the rest are deliberately dropped.
    assign unused_off_bits = ^{off[31:19], off[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdata_hi_q  <= wdata_hi_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    // Bus outputs are registered: each state's bus values are loaded on the
    // edge that enters the state, so they are stable for its whole duration.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdata_hi_d  = wdata_hi_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;
        ready       = 1'b0;

        case (state_q)
            IDLE: begin
                ready = !req;
                if (req) begin
                    is_wr_d     = mem_write;
                    word_d      = off[18:2];
                    wdata_hi_d  = write_data[31:16];
                    state_d     = LOW;
                    cnt_d       = '0;
                    sram_addr_d = {off[18:2], 1'b0};
                    dq_out_d    = write_data[15:0];
                    dq_oe_d     = mem_write;
                    we_n_d      = !mem_write;
                end
            end
            LOW: begin
                if (cnt_q == CNT_LAST) begin
                    if (!is_wr_q) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                    state_d     = HIGH;
                    cnt_d       = '0;
                    sram_addr_d = {word_q, 1'b1};
                    dq_out_d    = wdata_hi_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    if (!is_wr_q) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                    state_d = DONE;
                    cnt_d   = '0;
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // The request still visible here is the one completing now.
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//
// Directed bench for sram_controller. The main instance (ACCESS_CYCLES=2)
// talks to a behavioural 16-bit SRAM. Two more instances (ACCESS_CYCLES=1 and
// ACCESS_CYCLES=3) are used only for latency checks.
// ---------------------------------------------------------------------------
module tb_sram_controller;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    // Latency-only instances
    logic        mr_l, mw_l;
    logic [31:0] addr_l, wd_l;
    logic [31:0] rd1, rd3;
    logic        ready1, ready3;
    logic [17:0] sa1, sa3;
    logic [15:0] dqo1, dqo3;
    logic        oe1, oe3, wen1, wen3;

    always #5 clk = ~clk;

    sram_controller #(.ACCESS_CYCLES(AC), .DATA_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_controller #(.ACCESS_CYCLES(1), .DATA_BASE(32'd1024)) dut1 (
        .clk(clk), .rst(rst), .mem_read(mr_l), .mem_write(mw_l),
        .address(addr_l), .write_data(wd_l), .read_data(rd1),
        .ready(ready1), .sram_addr(sa1), .sram_dq_out(dqo1),
        .sram_dq_oe(oe1), .sram_dq_in(16'h0000), .sram_we_n(wen1)
    );

    sram_controller #(.ACCESS_CYCLES(3), .DATA_BASE(32'd1024)) dut3 (
        .clk(clk), .rst(rst), .mem_read(mr_l), .mem_write(mw_l),
        .address(addr_l), .write_data(wd_l), .read_data(rd3),
        .ready(ready3), .sram_addr(sa3), .sram_dq_out(dqo3),
        .sram_dq_oe(oe3), .sram_dq_in(16'h0000), .sram_we_n(wen3)
    );

    // Behavioural asynchronous-read SRAM
    bit [15:0] sram_mem [0:262143];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end

    // Reference word store and read scoreboard
    logic [31:0] ref_words [int];
    logic [31:0] exp_q [$];
    logic [31:0] exp_rd;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request and checks every cycle through DONE. Call at
    // negedge+1; returns at negedge+1 of the DONE cycle with inputs held.
    // b2b=1 means the call is made during DONE of the previous access.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [17:0] base_sa,
                          input bit b2b, input string tag);
        logic [31:0] o;
        int          widx;
        bit          is_w;
        logic [17:0] exp_sa;
        is_w = wr;
        o    = addr - 32'd1024;
        widx = int'(o[18:2]);
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wd;
        if (is_w) ref_words[widx] = wd;
        else      exp_q.push_back(ref_words.exists(widx) ? ref_words[widx] : 32'h0);
        if (b2b) begin
            #1 chk({tag, "_done_ready"}, ready, 1);
            @(negedge clk);
        end
        #1 chk({tag, "_c0_ready"}, ready, 0);
        for (int c = 1; c <= 2*AC; c++) begin
            @(negedge clk); #1;
            exp_sa = base_sa | 18'(c > AC);
            chk($sformatf("%s_c%0d_ready", tag, c), ready, 0);
            chk($sformatf("%s_c%0d_addr", tag, c), sram_addr, exp_sa);
            chk($sformatf("%s_c%0d_we_n", tag, c), sram_we_n, !is_w);
            chk($sformatf("%s_c%0d_oe", tag, c), sram_dq_oe, is_w);
            if (is_w)
                chk($sformatf("%s_c%0d_dq", tag, c), sram_dq_out,
                    (c > AC) ? wd[31:16] : wd[15:0]);
        end
        @(negedge clk); #1;
        chk({tag, "_done_ready1"}, ready, 1);
        chk({tag, "_done_we_n"}, sram_we_n, 1);
        chk({tag, "_done_oe"}, sram_dq_oe, 0);
        if (!is_w) begin
            if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
            else exp_rd = exp_q.pop_front();
        end
        chk({tag, "_read_data"}, read_data, exp_rd);
    endtask

    task automatic idle_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        int lat1, lat3;
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
        mr_l = 1'b0; mw_l = 1'b0; addr_l = '0; wd_l = '0;
        exp_rd = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_read_data", read_data, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe", sram_dq_oe, 0);
        chk("rst_ready", ready, 1);
        chk("rst_addr", sram_addr, 0);
        rst = 1'b1;
        idle_cycle();

        access(0, 1, 32'd1032, 32'hDEADBEEF, 18'd4, 0, "str8");
        idle_cycle();
        access(1, 0, 32'd1032, 32'h0, 18'd4, 0, "ldr8");
        idle_cycle();
        access(1, 1, 32'd1024, 32'h12345678, 18'd0, 0, "both");
        access(1, 0, 32'd1024, 32'h0, 18'd0, 1, "ldr0");
        idle_cycle();
        access(0, 1, 32'd1024 + 32'd4092, 32'hCAFEF00D, 18'd2046, 0, "str1023");
        access(1, 0, 32'd1024 + 32'd4092, 32'h0, 18'd2046, 1, "ldr1023");
        access(1, 0, 32'd1024 + 32'd4095, 32'h0, 18'd2046, 1, "ldr1023_b11");
        idle_cycle();
        // Address below DATA_BASE wraps: off=0xFFFFFC00 -> word 0x1FF00
        access(0, 1, 32'd0, 32'h0BADCAFE, 18'h3FE00, 0, "str_wrap");
        access(1, 0, 32'd0, 32'h0, 18'h3FE00, 1, "ldr_wrap");
        idle_cycle();

        // Latency for ACCESS_CYCLES = 1 and 3
        mw_l = 1'b1; addr_l = 32'd1024; wd_l = 32'hA5A5A5A5;
        #1;
        chk("lat_c0_ready1", ready1, 0);
        chk("lat_c0_ready3", ready3, 0);
        lat1 = -1; lat3 = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #1;
            if (ready1 && lat1 < 0) lat1 = c;
            if (ready3 && lat3 < 0) lat3 = c;
            if (lat3 >= 0) break;
        end
        mw_l = 1'b0;
        chk("lat_ac1", lat1, 3);
        chk("lat_ac3", lat3, 7);
        repeat (6) @(negedge clk);
        #1;

        // Asynchronous reset in the middle of HIGH
        mem_write = 1'b1; address = 32'd1024 + 32'd16; write_data = 32'h55AA33CC;
        repeat (3) @(negedge clk);
        #1;
        chk("midhigh_addr", sram_addr, 18'd9);
        chk("midhigh_we_n", sram_we_n, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_read_data", read_data, 0);
        chk("arst_addr", sram_addr, 0);
        chk("arst_dq", sram_dq_out, 0);
        chk("arst_oe", sram_dq_oe, 0);
        chk("arst_we_n", sram_we_n, 1);
        mem_write = 1'b0;
        #1;
        chk("arst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_ready", ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
